// File: rtl/lab2_proc_mem_responder.sv
// lab2_proc_mem_responder: byte-addressed word memory answering requests through a latency pipeline and response FIFO
module lab2_proc_mem_responder #(
  parameter int p_mem_nwords = 256,
  parameter int p_latency    = 0,
  parameter int p_resp_depth = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [76:0] memreq_msg,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  output logic [46:0] memresp_msg,
  output logic        memresp_val,
  input  logic        memresp_rdy
);
  localparam int aw = $clog2(p_mem_nwords);
  localparam int pw = p_resp_depth > 1 ? $clog2(p_resp_depth) : 1;
  localparam int cw = $clog2(p_resp_depth + p_latency + 1);
  logic [2:0] req_type;
  logic [7:0] req_opaque;
  logic [31:0] req_addr, req_data;
  logic [1:0] req_len;
  logic unused_addr;
  logic [31:0] mem [p_mem_nwords];
  logic [aw-1:0] idx;
  logic [3:0] len_mask, byte_mask;
  logic [31:0] word_mask, word, rdata;
  logic [4:0] sh;
  logic go, wr, deq, enq_val;
  logic [46:0] resp, enq_msg;
  logic [cw-1:0] inflight, count;
  logic [pw-1:0] head, tail;
  logic [46:0] fifo [p_resp_depth];
  assign {req_type, req_opaque, req_addr, req_len, req_data} = memreq_msg;
  assign unused_addr = ^req_addr[31:aw+2];
  assign idx = req_addr[aw+1:2];
  assign sh = {req_addr[1:0], 3'b0};
  assign len_mask = req_len == 2'd0 ? 4'hf : (4'd1 << req_len) - 4'd1;
  assign byte_mask = len_mask << req_addr[1:0];
  assign word_mask = {{8{byte_mask[3]}}, {8{byte_mask[2]}}, {8{byte_mask[1]}}, {8{byte_mask[0]}}};
  assign word = mem[idx];
  assign rdata = (word & word_mask) >> sh;
  assign go = memreq_val && memreq_rdy;
  assign wr = go && (req_type == 3'd1 || req_type == 3'd2);
  assign resp = {req_type, req_opaque, 2'b0, req_len, req_type == 3'd0 ? rdata : 32'd0};
  always_ff @(posedge clk)
    if (wr) mem[idx] <= (word & ~word_mask) | ((req_data << sh) & word_mask);
  generate
    if (p_latency == 0) begin : g_direct
      assign enq_val = go;
      assign enq_msg = resp;
      assign inflight = '0;
    end else begin : g_pipe
      logic [p_latency-1:0] pv;
      logic [46:0] pm [p_latency];
      always_ff @(posedge clk) begin
        pv[0] <= !reset && go;
        pm[0] <= resp;
        for (int i = 1; i < p_latency; i++) begin
          pv[i] <= !reset && pv[i-1];
          pm[i] <= pm[i-1];
        end
      end
      assign enq_val = pv[p_latency-1];
      assign enq_msg = pm[p_latency-1];
      assign inflight = cw'($countones(pv));
    end
  endgenerate
  assign deq = memresp_val && memresp_rdy;
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= deq ? (head == pw'(p_resp_depth - 1) ? '0 : head + 1'b1) : head;
      tail <= enq_val ? (tail == pw'(p_resp_depth - 1) ? '0 : tail + 1'b1) : tail;
      count <= count + cw'(enq_val) - cw'(deq);
    end
    if (enq_val) fifo[tail] <= enq_msg;
  end
  assign memresp_msg = fifo[head];
  assign memresp_val = !reset && count != '0;
  assign memreq_rdy = !reset && (count + inflight) < cw'(p_resp_depth);
endmodule

// File: tb/tb_lab2_proc_mem_responder.sv
// tb_lab2_proc_mem_responder: directed and random checks of two responder configurations against a byte-level model
module tb_lab2_proc_mem_responder;
  logic clk = 0;
  logic reset = 1;
  logic [76:0] rq_msg [2];
  logic rq_val [2];
  logic rq_rdy [2];
  logic [46:0] rs_msg [2];
  logic rs_val [2];
  logic rs_rdy [2];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] mb [2][1024];
  logic [46:0] em [2][64];
  int et [2][64];
  int qh [2];
  int qt [2];
  logic [46:0] cap [2][64];
  int ng [2];
  logic done0, done1;
  lab2_proc_mem_responder dut0 (
    .clk(clk), .reset(reset),
    .memreq_msg(rq_msg[0]), .memreq_val(rq_val[0]), .memreq_rdy(rq_rdy[0]),
    .memresp_msg(rs_msg[0]), .memresp_val(rs_val[0]), .memresp_rdy(rs_rdy[0])
  );
  lab2_proc_mem_responder #(.p_latency(3), .p_resp_depth(4)) dut1 (
    .clk(clk), .reset(reset),
    .memreq_msg(rq_msg[1]), .memreq_val(rq_val[1]), .memreq_rdy(rq_rdy[1]),
    .memresp_msg(rs_msg[1]), .memresp_val(rs_val[1]), .memresp_rdy(rs_rdy[1])
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [76:0] req(logic [2:0] t, logic [7:0] o, logic [31:0] a, logic [1:0] l, logic [31:0] d);
    return {t, o, a, l, d};
  endfunction
  function automatic logic [46:0] model(int u, logic [76:0] m);
    logic [2:0] t = m[76:74];
    int n = m[33:32] == 2'd0 ? 4 : int'(m[33:32]);
    int off = int'(m[35:34]);
    int base = int'(m[43:36]) * 4;
    logic [31:0] rd = 32'd0;
    for (int i = 0; i < n; i++)
      if (off + i < 4) begin
        if (t == 3'd0) rd[8*i +: 8] = mb[u][base + off + i];
        if (t == 3'd1 || t == 3'd2) mb[u][base + off + i] = m[8*i +: 8];
      end
    return {t, m[73:66], 2'b0, m[33:32], t == 3'd0 ? rd : 32'd0};
  endfunction
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        chk($sformatf("rst_rdy%0d", u), rq_rdy[u], 0);
        chk($sformatf("rst_val%0d", u), rs_val[u], 0);
        qh[u] = qt[u];
      end else begin
        chk($sformatf("rdy%0d", u), rq_rdy[u], (qt[u] - qh[u]) < (u == 0 ? 2 : 4));
        chk($sformatf("val%0d", u), rs_val[u], qt[u] != qh[u] && et[u][qh[u] % 64] <= cyc);
        if (rs_val[u] && rs_rdy[u] && qt[u] != qh[u]) begin
          chk($sformatf("msg%0d", u), rs_msg[u], em[u][qh[u] % 64]);
          cap[u][ng[u] % 64] = rs_msg[u];
          ng[u]++;
          qh[u]++;
        end
        if (rq_val[u] && rq_rdy[u]) begin
          em[u][qt[u] % 64] = model(u, rq_msg[u]);
          et[u][qt[u] % 64] = cyc + (u == 0 ? 0 : 3) + 1;
          qt[u]++;
        end
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input int u, input logic [76:0] m);
    logic ok = 0;
    rq_msg[u] = m;
    rq_val[u] = 1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = rq_rdy[u];
    end
    chk("send_timeout", ok, 1);
    @(posedge clk);
    #1 rq_val[u] = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int k, t0;
    rq_val[0] = 0; rq_val[1] = 0;
    rs_rdy[0] = 1; rs_rdy[1] = 1;
    rq_msg[0] = '0; rq_msg[1] = '0;
    qh = '{0, 0}; qt = '{0, 0}; ng = '{0, 0};
    done0 = 0; done1 = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rdy_after_rst", rq_rdy[0], 1);
    idle(1);
    k = ng[0];
    send(0, req(3'd1, 8'h05, 32'h10, 2'd0, 32'hdeadbeef));
    send(0, req(3'd0, 8'h06, 32'h10, 2'd0, 32'd0));
    idle(4);
    chk("wr_count", ng[0] - k, 2);
    chk("wr_type", cap[0][k % 64][46:44], 1);
    chk("wr_op", cap[0][k % 64][43:36], 8'h05);
    chk("wr_data", cap[0][k % 64][31:0], 0);
    chk("rd_op", cap[0][(k + 1) % 64][43:36], 8'h06);
    chk("rd_data", cap[0][(k + 1) % 64][31:0], 32'hdeadbeef);
    k = ng[0];
    send(0, req(3'd1, 8'h07, 32'h11, 2'd1, 32'h000000aa));
    send(0, req(3'd0, 8'h08, 32'h10, 2'd0, 32'd0));
    send(0, req(3'd0, 8'h09, 32'h12, 2'd2, 32'd0));
    idle(4);
    chk("byte_wr_rd", cap[0][(k + 1) % 64][31:0], 32'hdeadaaef);
    chk("half_rd", cap[0][(k + 2) % 64][31:0], 32'h0000dead);
    for (int i = 0; i < 4; i++) send(1, req(3'd1, 8'(i), 32'h100 + 32'(4 * i), 2'd0, 32'ha0a00000 + 32'(i)));
    idle(6);
    k = ng[1];
    t0 = cyc;
    for (int i = 0; i < 4; i++) send(1, req(3'd0, 8'h10 + 8'(i), 32'h100 + 32'(4 * i), 2'd0, 32'd0));
    chk("lat_b2b_cycles", cyc - t0, 4);
    idle(8);
    for (int i = 0; i < 4; i++) begin
      chk("lat_op", cap[1][(k + i) % 64][43:36], 8'h10 + 8'(i));
      chk("lat_data", cap[1][(k + i) % 64][31:0], 32'ha0a00000 + 32'(i));
    end
    rs_rdy[0] = 0;
    k = ng[0];
    send(0, req(3'd0, 8'h21, 32'h10, 2'd0, 32'd0));
    send(0, req(3'd0, 8'h22, 32'h10, 2'd0, 32'd0));
    rq_msg[0] = req(3'd0, 8'h23, 32'h10, 2'd0, 32'd0);
    rq_val[0] = 1;
    @(negedge clk);
    chk("full_rdy", rq_rdy[0], 0);
    idle(1);
    @(negedge clk);
    chk("full_hold_op", rs_msg[0][43:36], 8'h21);
    idle(1);
    rs_rdy[0] = 1;
    @(negedge clk);
    chk("deq_rdy_still_low", rq_rdy[0], 0);
    idle(1);
    @(negedge clk);
    chk("rdy_after_deq", rq_rdy[0], 1);
    @(posedge clk);
    #1 rq_val[0] = 0;
    idle(4);
    for (int i = 0; i < 3; i++) chk("order_op", cap[0][(k + i) % 64][43:36], 8'h21 + 8'(i));
    k = ng[0];
    send(0, req(3'd1, 8'h30, 32'h400, 2'd0, 32'h12345678));
    send(0, req(3'd0, 8'h31, 32'h0, 2'd0, 32'd0));
    idle(4);
    chk("wrap_data", cap[0][(k + 1) % 64][31:0], 32'h12345678);
    rs_rdy[0] = 0;
    send(0, req(3'd0, 8'h40, 32'h10, 2'd0, 32'd0));
    send(0, req(3'd0, 8'h41, 32'h0, 2'd0, 32'd0));
    idle(1);
    @(negedge clk);
    chk("buffered_val", rs_val[0], 1);
    idle(1);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_val", rs_val[0], 0);
    idle(2);
    reset = 0;
    rs_rdy[0] = 1;
    k = ng[0];
    idle(5);
    chk("no_stale", ng[0] - k, 0);
    send(0, req(3'd0, 8'h42, 32'h10, 2'd0, 32'd0));
    idle(3);
    chk("persist_data", cap[0][k % 64][31:0], 32'hdeadaaef);
    fork
      begin
        for (int w = 0; w < 16; w++) send(0, req(3'd1, 8'(w), 32'(4 * w), 2'd0, $urandom));
        for (int i = 0; i < 150; i++) begin
          int r = $urandom_range(0, 9);
          send(0, req(r < 4 ? 3'd0 : r < 6 ? 3'd1 : r == 6 ? 3'd2 : 3'(r - 4), 8'($urandom),
                      {$urandom_range(0, 4194303) , 4'b0, 4'($urandom), 2'($urandom)} , 2'($urandom), $urandom));
        end
        done0 = 1;
      end
      begin
        for (int w = 0; w < 16; w++) send(1, req(3'd1, 8'(w), 32'(4 * w), 2'd0, $urandom));
        for (int i = 0; i < 150; i++) begin
          int r = $urandom_range(0, 9);
          send(1, req(r < 4 ? 3'd0 : r < 6 ? 3'd1 : r == 6 ? 3'd2 : 3'(r - 4), 8'($urandom),
                      {$urandom_range(0, 4194303) , 4'b0, 4'($urandom), 2'($urandom)} , 2'($urandom), $urandom));
        end
        done1 = 1;
      end
      begin
        while (!done0 || !done1) begin
          @(posedge clk);
          #1;
          rs_rdy[0] = 1'($urandom);
          rs_rdy[1] = 1'($urandom);
        end
      end
    join
    rs_rdy[0] = 1;
    rs_rdy[1] = 1;
    idle(20);
    chk("drain0", qt[0] - qh[0], 0);
    chk("drain1", qt[1] - qh[1], 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
